// File: rtl/sgd_gradient_sched_if.sv
// -----------------------------------------------------------------------------
// sgd_gradient_sched_if
// Bundles the read-stream signals between the gradient scheduler and the
// A-bit FIFO / gradient datapath, plus the dot-product handshake.
//   master : scheduler side   (drives fifo_a_rd_en, dot_ready, rd_* tags)
//   slave  : environment side (drives fifo_a_empty, dot_valid)
// Signals:
//   fifo_a_empty   A-bit FIFO empty flag
//   fifo_a_rd_en   FIFO read strobe
//   dot_valid      one-cycle pulse, dot-product result ready
//   dot_ready      scheduler is waiting for a dot-product result
//   rd_bit_index   bit-plane of the current read
//   rd_chunk_index chunk of the current read
//   rd_last        current read is the last read of the sample
// -----------------------------------------------------------------------------
interface sgd_gradient_sched_if #(
    parameter int CNT_W = 12
) ();
    logic             fifo_a_empty;
    logic             fifo_a_rd_en;
    logic             dot_valid;
    logic             dot_ready;
    logic [4:0]       rd_bit_index;
    logic [CNT_W-1:0] rd_chunk_index;
    logic             rd_last;

    modport master (
        input  fifo_a_empty,
        input  dot_valid,
        output fifo_a_rd_en,
        output dot_ready,
        output rd_bit_index,
        output rd_chunk_index,
        output rd_last
    );

    modport slave (
        output fifo_a_empty,
        output dot_valid,
        input  fifo_a_rd_en,
        input  dot_ready,
        input  rd_bit_index,
        input  rd_chunk_index,
        input  rd_last
    );
endinterface

// File: rtl/sgd_gradient_sched.sv
// -----------------------------------------------------------------------------
// sgd_gradient_sched
// Sequencer for the gradient stage of the SGD engine. Latches the run
// configuration, tracks epoch/sample progress and, after every dot-product
// result, issues chunks*bits reads from the A-bit FIFO, each tagged with its
// bit-plane and chunk index. Handles FIFO underflow stalls (reads simply
// pause), dot-product results that arrive early (one is buffered as
// "pending", a second one is dropped and flagged) and run abort (started low).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   started               run-enable level; rising edge starts, low aborts
//   number_of_epochs      epochs per run
//   number_of_samples     samples per epoch
//   dimension             features per sample
//   number_of_bits        bit-planes per feature (bits [5:0] used, clamped 1..16)
//   sif (master)          FIFO read stream + dot-product handshake
//   sample_done           one-cycle pulse at sample end
//   epoch_done            one-cycle pulse at epoch end
//   all_done              level, run complete
//   busy                  scheduler in an active state
//   err_overrun           sticky, a dot_valid pulse was dropped
//   cur_epoch, cur_sample progress counters
//
// Optional feature (macro SGD_GRAD_SCHED_PERF_EN):
//   stall_cycles          ISSUE cycles spent with the FIFO empty (saturating)
//   wait_cycles           cycles spent in WAIT_DOT (saturating)
//   Both clear when a new run is configured.
// -----------------------------------------------------------------------------
module sgd_gradient_sched #(
    parameter int CHUNK_SHIFT = 9,
    parameter int CNT_W       = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        started,
    input  logic [31:0]                 number_of_epochs,
    input  logic [31:0]                 number_of_samples,
    input  logic [31:0]                 dimension,
    input  logic [31:0]                 number_of_bits,
    sgd_gradient_sched_if.master        sif,
    output logic                        sample_done,
    output logic                        epoch_done,
    output logic                        all_done,
    output logic                        busy,
    output logic                        err_overrun,
    output logic [31:0]                 cur_epoch,
    output logic [31:0]                 cur_sample
`ifdef SGD_GRAD_SCHED_PERF_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 wait_cycles
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CFG        = 3'd1,
        ST_WAIT_DOT   = 3'd2,
        ST_ISSUE      = 3'd3,
        ST_SAMPLE_END = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    localparam logic [32:0] CHUNK_ROUND = 33'((33'd1 << CHUNK_SHIFT) - 33'd1);
    localparam logic [32:0] CHUNK_MAX   = 33'((33'd1 << CNT_W) - 33'd1);

    // Number of chunks for a dimension: ceil(dim / 2^CHUNK_SHIFT), computed
    // in 33 bits so the rounding add cannot wrap, then saturated to CNT_W.
    function automatic logic [CNT_W-1:0] calc_chunks(input logic [31:0] dim);
        logic [32:0] sum;
        logic [32:0] quo;
        sum = {1'b0, dim} + CHUNK_ROUND;
        quo = sum >> CHUNK_SHIFT;
        if (quo > CHUNK_MAX) begin
            calc_chunks = CHUNK_MAX[CNT_W-1:0];
        end else begin
            calc_chunks = quo[CNT_W-1:0];
        end
    endfunction

    // Bit-plane count clamp: 0 is treated as 1, anything above 16 as 16.
    function automatic logic [4:0] clamp_bits(input logic [5:0] nb);
        if (nb == 6'd0) begin
            clamp_bits = 5'd1;
        end else if (nb > 6'd16) begin
            clamp_bits = 5'd16;
        end else begin
            clamp_bits = nb[4:0];
        end
    endfunction

    state_t           state_q, state_d;
    logic             started_q;
    logic [31:0]      epochs_q, epochs_d;
    logic [31:0]      samples_q, samples_d;
    logic [CNT_W-1:0] chunks_q, chunks_d;
    logic [4:0]       bits_q, bits_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] chunk_idx_q, chunk_idx_d;
    logic [31:0]      cur_epoch_q, cur_epoch_d;
    logic [31:0]      cur_sample_q, cur_sample_d;
    logic             pending_q, pending_d;
    logic             err_overrun_q, err_overrun_d;

    logic             start_rise_s;
    logic             cfg_zero_s;
    logic             rd_en_s;
    logic             last_bit_s;
    logic             last_chunk_s;
    logic             rd_last_s;
    logic             sample_last_s;
    logic             epoch_last_s;
    logic             unused_nb_hi_s;

    // Only the low six bits of number_of_bits carry meaning.
    assign unused_nb_hi_s = ^number_of_bits[31:6];

    assign start_rise_s  = started & ~started_q;
    assign cfg_zero_s    = (number_of_epochs == 32'd0) | (number_of_samples == 32'd0) |
                           (dimension == 32'd0);
    // Gated by started so an abort kills the strobe in the same cycle.
    assign rd_en_s       = (state_q == ST_ISSUE) & ~sif.fifo_a_empty & started;
    assign last_bit_s    = (bit_idx_q == (bits_q - 5'd1));
    assign last_chunk_s  = (chunk_idx_q == (chunks_q - CNT_W'(1)));
    assign rd_last_s     = (state_q == ST_ISSUE) & last_bit_s & last_chunk_s;
    assign sample_last_s = (cur_sample_q == (samples_q - 32'd1));
    assign epoch_last_s  = (cur_epoch_q == (epochs_q - 32'd1));

    // Output mapping from registered state and counters.
    assign sif.fifo_a_rd_en   = rd_en_s;
    assign sif.dot_ready      = (state_q == ST_WAIT_DOT);
    assign sif.rd_bit_index   = bit_idx_q;
    assign sif.rd_chunk_index = chunk_idx_q;
    assign sif.rd_last        = rd_last_s;
    assign sample_done        = (state_q == ST_SAMPLE_END) & started;
    assign epoch_done         = (state_q == ST_SAMPLE_END) & started & sample_last_s;
    assign all_done           = (state_q == ST_DONE);
    assign busy               = (state_q != ST_IDLE) & (state_q != ST_DONE);
    assign err_overrun        = err_overrun_q;
    assign cur_epoch          = cur_epoch_q;
    assign cur_sample         = cur_sample_q;

    // State register and datapath flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            started_q     <= 1'b0;
            epochs_q      <= 32'd0;
            samples_q     <= 32'd0;
            chunks_q      <= {CNT_W{1'b0}};
            bits_q        <= 5'd0;
            bit_idx_q     <= 5'd0;
            chunk_idx_q   <= {CNT_W{1'b0}};
            cur_epoch_q   <= 32'd0;
            cur_sample_q  <= 32'd0;
            pending_q     <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            started_q     <= started;
            epochs_q      <= epochs_d;
            samples_q     <= samples_d;
            chunks_q      <= chunks_d;
            bits_q        <= bits_d;
            bit_idx_q     <= bit_idx_d;
            chunk_idx_q   <= chunk_idx_d;
            cur_epoch_q   <= cur_epoch_d;
            cur_sample_q  <= cur_sample_d;
            pending_q     <= pending_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // Next-state, counter and pending/overrun logic.
    always_comb begin
        state_d       = state_q;
        epochs_d      = epochs_q;
        samples_d     = samples_q;
        chunks_d      = chunks_q;
        bits_d        = bits_q;
        bit_idx_d     = bit_idx_q;
        chunk_idx_d   = chunk_idx_q;
        cur_epoch_d   = cur_epoch_q;
        cur_sample_d  = cur_sample_q;
        pending_d     = pending_q;
        err_overrun_d = err_overrun_q;

        // A result arriving while we cannot accept it is buffered once; a
        // second one before the buffer drains is lost and flagged. In CFG the
        // clear and the capture happen together, capture winning.
        case (state_q)
            ST_CFG: begin
                pending_d     = sif.dot_valid;
                err_overrun_d = 1'b0;
            end
            ST_ISSUE, ST_SAMPLE_END: begin
                if (sif.dot_valid) begin
                    if (pending_q) begin
                        err_overrun_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end else begin
                    pending_d = pending_q;
                end
            end
            default: begin
                pending_d = pending_q;
            end
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start_rise_s) begin
                    state_d = ST_CFG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CFG: begin
                epochs_d     = number_of_epochs;
                samples_d    = number_of_samples;
                chunks_d     = calc_chunks(dimension);
                bits_d       = clamp_bits(number_of_bits[5:0]);
                bit_idx_d    = 5'd0;
                chunk_idx_d  = {CNT_W{1'b0}};
                cur_epoch_d  = 32'd0;
                cur_sample_d = 32'd0;
                if (!started) begin
                    state_d = ST_IDLE;
                end else if (cfg_zero_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_DOT;
                end
            end
            ST_WAIT_DOT: begin
                if (!started) begin
                    state_d = ST_IDLE;
                end else if (sif.dot_valid | pending_q) begin
                    state_d   = ST_ISSUE;
                    // Buffered result is consumed first; a fresh pulse in the
                    // same cycle takes its place in the buffer.
                    pending_d = pending_q & sif.dot_valid;
                end else begin
                    state_d = ST_WAIT_DOT;
                end
            end
            ST_ISSUE: begin
                if (!started) begin
                    state_d = ST_IDLE;
                end else if (rd_en_s) begin
                    if (rd_last_s) begin
                        bit_idx_d   = 5'd0;
                        chunk_idx_d = {CNT_W{1'b0}};
                        state_d     = ST_SAMPLE_END;
                    end else if (last_bit_s) begin
                        bit_idx_d   = 5'd0;
                        chunk_idx_d = chunk_idx_q + CNT_W'(1);
                        state_d     = ST_ISSUE;
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                        state_d   = ST_ISSUE;
                    end
                end else begin
                    // FIFO empty: hold indices until data is available.
                    state_d = ST_ISSUE;
                end
            end
            ST_SAMPLE_END: begin
                if (!started) begin
                    state_d = ST_IDLE;
                end else if (sample_last_s) begin
                    cur_sample_d = 32'd0;
                    cur_epoch_d  = cur_epoch_q + 32'd1;
                    if (epoch_last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_DOT;
                    end
                end else begin
                    cur_sample_d = cur_sample_q + 32'd1;
                    state_d      = ST_WAIT_DOT;
                end
            end
            ST_DONE: begin
                if (!started) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef SGD_GRAD_SCHED_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] wait_cycles_q, wait_cycles_d;

    assign stall_cycles = stall_cycles_q;
    assign wait_cycles  = wait_cycles_q;

    // Performance counter flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            wait_cycles_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            wait_cycles_q  <= wait_cycles_d;
        end
    end

    // Saturating stall/wait counters, cleared when a run is configured.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        wait_cycles_d  = wait_cycles_q;
        if (state_q == ST_CFG) begin
            stall_cycles_d = 32'd0;
            wait_cycles_d  = 32'd0;
        end else begin
            if ((state_q == ST_ISSUE) && sif.fifo_a_empty && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_d = stall_cycles_q + 32'd1;
            end else begin
                stall_cycles_d = stall_cycles_q;
            end
            if ((state_q == ST_WAIT_DOT) && (wait_cycles_q != 32'hFFFF_FFFF)) begin
                wait_cycles_d = wait_cycles_q + 32'd1;
            end else begin
                wait_cycles_d = wait_cycles_q;
            end
        end
    end
`endif

endmodule

// File: doc/sgd_gradient_sched.md
# sgd_gradient_sched

Sequencer for the gradient stage of the SGD engine. It latches the run configuration and tracks epoch and sample progress. After each dot-product result it issues exactly chunks×bits reads from the A-bit FIFO, each tagged with bit-plane and chunk indices, so the gradient datapath sees a gap-free, correctly framed read stream. It also handles FIFO underflow stalls, early dot-product arrival and run abort.

## Interface
Parameters:
- CHUNK_SHIFT, 9: log2 of features per chunk; chunks = ceil(dimension / 2^CHUNK_SHIFT).
- CNT_W, 12: width of the chunk counter; chunk count saturates at 2^CNT_W−1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- started  in  1  run-enable level; rising edge starts a run, low aborts.
- number_of_epochs  in  32  epochs per run.
- number_of_samples  in  32  samples per epoch.
- dimension  in  32  features per sample.
- number_of_bits  in  32  bit-planes per feature; bits [5:0] are used.
- fifo_a_empty  in  1  A-bit FIFO empty.
- fifo_a_rd_en  out  1  FIFO read strobe; combinational.
- dot_valid  in  1  one-cycle pulse: a dot-product result for the next sample is ready.
- dot_ready  out  1  high in WAIT_DOT.
- rd_bit_index  out  5  bit-plane of the current read.
- rd_chunk_index  out  CNT_W  chunk of the current read.
- rd_last  out  1  the current read is the last read of the sample.
- sample_done  out  1  one-cycle pulse at sample end.
- epoch_done  out  1  one-cycle pulse at epoch end.
- all_done  out  1  level; the run is complete.
- busy  out  1  state not in {IDLE, DONE}.
- err_overrun  out  1  sticky; a dot_valid was dropped.
- cur_epoch, cur_sample  out  32 each  progress counters.

## Operation
- States: IDLE, CFG, WAIT_DOT, ISSUE, SAMPLE_END, DONE.
- IDLE → CFG on a started rising edge, detected with a registered copy of started.
- CFG (1 cycle):
  - Latch epochs, samples, chunks and bits.
  - Clamp bits: 0 → 1, >16 → 16.
  - If epochs, samples or dimension is 0, go to DONE; otherwise go to WAIT_DOT.
  - Clear counters, the pending flag and err_overrun.
- WAIT_DOT: go to ISSUE when dot_valid=1 or pending=1. Clear pending on that transition.
- ISSUE:
  - fifo_a_rd_en = (state==ISSUE) & ~fifo_a_empty & started.
  - On each read, bit_index increments. When it reaches bits−1 it wraps to 0 and chunk_index increments.
  - rd_last = (chunk_index==chunks−1) & (bit_index==bits−1).
  - A read with rd_last set moves to SAMPLE_END.
  - Empty FIFO: hold the state and indices; no read is issued.
- SAMPLE_END (1 cycle):
  - Pulse sample_done and increment cur_sample.
  - If cur_sample==samples−1: set cur_sample to 0, pulse epoch_done and increment cur_epoch.
  - If cur_epoch==epochs−1 at that point: go to DONE. Otherwise go to WAIT_DOT.
- DONE: all_done=1. When started goes low, go to IDLE and clear all_done.
- dot_valid during CFG, ISSUE or SAMPLE_END sets pending. If pending is already 1, the pulse is dropped and err_overrun is set.
- started low in any active state: next state is IDLE. fifo_a_rd_en drops in the same cycle because it is gated by started. Counters hold their values until the next CFG.
- rd_bit_index and rd_chunk_index are registered counters, valid whenever fifo_a_rd_en=1.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Counters, pending and err_overrun 0.
- dot_valid at cycle t in WAIT_DOT: state is ISSUE at t+1; first fifo_a_rd_en at t+1 if the FIFO is not empty.
- Reads per sample: chunks×bits, back-to-back when the FIFO is not empty.
- The last read at cycle t gives sample_done at t+1. The following WAIT_DOT can accept at t+2; with pending set, ISSUE is entered at t+3.
- Chunk count arithmetic uses 33 bits internally; the result saturates to CNT_W bits.

## Configuration
- Macro SGD_GRAD_SCHED_PERF_EN.
- Defined:
  - Adds outputs stall_cycles[31:0], counting ISSUE cycles with fifo_a_empty=1.
  - Adds outputs wait_cycles[31:0], counting WAIT_DOT cycles.
  - Both saturate at all-ones and clear in CFG.
- Undefined: the ports and logic are absent; all other behaviour is identical.

## Test plan
- epochs=1, samples=2, dimension=1024, bits=4, FIFO never empty, dot_valid per sample:
  - 8 reads per sample with indices (b0,c0)…(b3,c1).
  - rd_last on the 8th read.
  - 2 sample_done pulses, 1 epoch_done, then all_done=1.
- dimension=513, bits=1: chunks=2, so 2 reads per sample. dimension=0: CFG goes straight to DONE and no read is issued.
- fifo_a_empty forced high for 5 cycles during ISSUE: no reads in those cycles, indices hold, and the read total still equals chunks×bits.
- dot_valid in the middle of ISSUE: pending is set and ISSUE resumes at t+3 after rd_last. A second dot_valid while pending sets err_overrun=1.
- started dropped in the middle of ISSUE: fifo_a_rd_en low in the same cycle and IDLE next cycle. A fresh rising edge restarts with counters at 0.
- bits=0 is read as 1; bits=20 gives 16 reads per chunk.
